// File: rtl/exec_hazard_ctrl.sv
// EX-stage hazard controller: issue/stall/bubble/flush decisions at the ID->EX
// boundary, registered forwarding selects and the multi-cycle EX hold.
module exec_hazard_ctrl #(
  parameter int unsigned RA_W      = 4,
  parameter int unsigned MULTI_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_ra,
  input  logic [RA_W-1:0] id_rb,
  input  logic [RA_W-1:0] id_rd3,
  input  logic [2:0]      id_use,
  input  logic            id_mode,
  input  logic            id_regwrite,
  input  logic [RA_W-1:0] id_rc,
  input  logic            id_memtoreg,
  input  logic            id_multi,
  input  logic            ex_branch,
  output logic            stall_id,
  output logic            flush_id,
  output logic            bubble_ex,
  output logic            ex_en,
  output logic            fa,
  output logic            fb,
  output logic            fc,
  output logic            ex_busy
);

  localparam int unsigned CNT_W = (MULTI_LAT > 2) ? $clog2(MULTI_LAT - 1) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef struct packed {
    logic            v;
    logic            mode;
    logic            wr;
    logic [RA_W-1:0] rc;
    logic            load;
    logic            multi;
  } ex_rec_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  ex_rec_t          rec;
  ex_rec_t          id_rec;

  logic match_a, match_b, match_c;
  logic load_use;
  logic hold;
  logic issue;

  // Producer in EX matches an in-use source of the same register namespace.
  assign match_a = id_use[0] & rec.v & rec.wr & (rec.mode == id_mode) & (rec.rc == id_ra);
  assign match_b = id_use[1] & rec.v & rec.wr & (rec.mode == id_mode) & (rec.rc == id_rb);
  assign match_c = id_use[2] & rec.v & rec.wr & (rec.mode == id_mode) & (rec.rc == id_rd3);

  assign load_use = rec.load & (match_a | match_b | match_c);

  assign id_rec = '{
    v:     1'b1,
    mode:  id_mode,
    wr:    id_regwrite,
    rc:    id_rc,
    load:  id_memtoreg,
    multi: id_multi
  };

  // The freeze starts in the first EX cycle of a multi op (still IDLE) and
  // releases in the last BUSY cycle (cnt==0) so the op leaves EX after
  // exactly MULTI_LAT cycles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hold    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rec.v & rec.multi) begin
          state_n = BUSY;
          cnt_n   = CNT_W'(MULTI_LAT - 2);
          hold    = 1'b1;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
          hold  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Hold outranks branch and load-use; branch outranks load-use.
  always_comb begin
    ex_en     = ~hold;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    if (hold) begin
      stall_id = 1'b1;
    end else if (ex_branch) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (load_use) begin
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  assign issue = id_valid & ~stall_id & ~flush_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      rec   <= '0;
      fa    <= 1'b0;
      fb    <= 1'b0;
      fc    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (ex_en) begin
        rec <= issue ? id_rec : '0;
        fa  <= issue & match_a & ~rec.load;
        fb  <= issue & match_b & ~rec.load;
        fc  <= issue & match_c & ~rec.load;
      end
    end
  end

  assign ex_busy = (state == BUSY);

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Directed bench for exec_hazard_ctrl: an occupancy/age model of the EX slot is
// compared on every falling edge, plus literal checks for each scenario.
module tb_exec_hazard_ctrl;

  localparam int ML = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [3:0] id_ra = '0, id_rb = '0, id_rd3 = '0, id_rc = '0;
  logic [2:0] id_use = '0;
  logic       id_mode = 1'b0, id_regwrite = 1'b0, id_memtoreg = 1'b0, id_multi = 1'b0;
  logic       ex_branch = 1'b0;
  logic       stall_id, flush_id, bubble_ex, ex_en, fa, fb, fc, ex_busy;

  int n_cmp = 0;
  int n_bad = 0;

  exec_hazard_ctrl #(.RA_W(4), .MULTI_LAT(ML)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb), .id_rd3(id_rd3),
    .id_use(id_use), .id_mode(id_mode), .id_regwrite(id_regwrite), .id_rc(id_rc),
    .id_memtoreg(id_memtoreg), .id_multi(id_multi), .ex_branch(ex_branch),
    .stall_id(stall_id), .flush_id(flush_id), .bubble_ex(bubble_ex), .ex_en(ex_en),
    .fa(fa), .fb(fb), .fc(fc), .ex_busy(ex_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // EX occupant model: what sits in EX and for how many cycles it has been there.
  logic m_v, m_mode, m_wr, m_load, m_multi, m_fa, m_fb, m_fc;
  logic [3:0] m_rc;
  int   m_age;
  logic n_v, n_mode, n_wr, n_load, n_multi, n_fa, n_fb, n_fc;
  logic [3:0] n_rc;
  int   n_age;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      {m_v, m_mode, m_wr, m_load, m_multi, m_fa, m_fb, m_fc} = '0;
      m_rc = '0; m_age = 0;
      {n_v, n_mode, n_wr, n_load, n_multi, n_fa, n_fb, n_fc} = '0;
      n_rc = '0; n_age = 0;
    end else begin
      {m_v, m_mode, m_wr, m_load, m_multi, m_fa, m_fb, m_fc} =
        {n_v, n_mode, n_wr, n_load, n_multi, n_fa, n_fb, n_fc};
      m_rc = n_rc; m_age = n_age;
    end
  end

  always @(negedge clk) begin
    logic ma, mb, mc, lu, hold, busy, e_stall, e_flush, e_bub, iss;
    if (rst) begin
      ma = id_use[0] && m_v && m_wr && m_mode == id_mode && m_rc == id_ra;
      mb = id_use[1] && m_v && m_wr && m_mode == id_mode && m_rc == id_rb;
      mc = id_use[2] && m_v && m_wr && m_mode == id_mode && m_rc == id_rd3;
      lu = m_load && (ma || mb || mc);
      hold = m_v && m_multi && m_age < ML;
      busy = m_v && m_multi && m_age >= 2;
      e_stall = hold || (lu && !ex_branch);
      e_flush = !hold && ex_branch;
      e_bub   = !hold && (ex_branch || lu);
      check("stall_id", stall_id, e_stall);
      check("flush_id", flush_id, e_flush);
      check("bubble_ex", bubble_ex, e_bub);
      check("ex_en", ex_en, !hold);
      check("ex_busy", ex_busy, busy);
      check("fa", fa, m_fa);
      check("fb", fb, m_fb);
      check("fc", fc, m_fc);
      iss = id_valid && !e_stall && !e_flush;
      if (hold) begin
        n_age = m_age + 1;
      end else begin
        n_v = iss; n_mode = id_mode; n_wr = id_regwrite; n_rc = id_rc;
        n_load = id_memtoreg; n_multi = id_multi; n_age = 1;
        n_fa = iss && ma && !m_load;
        n_fb = iss && mb && !m_load;
        n_fc = iss && mc && !m_load;
      end
    end
  end

  // Present one instruction in ID for the coming cycle.
  task automatic step(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [3:0] rd3, input logic [2:0] usem, input logic mode,
                      input logic wr, input logic [3:0] rc, input logic ld,
                      input logic mul, input logic br);
    @(posedge clk);
    #1;
    id_valid = v; id_ra = ra; id_rb = rb; id_rd3 = rd3; id_use = usem;
    id_mode = mode; id_regwrite = wr; id_rc = rc; id_memtoreg = ld;
    id_multi = mul; ex_branch = br;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("rst_stall", stall_id, 1'b0);
    check("rst_flush", flush_id, 1'b0);
    check("rst_bubble", bubble_ex, 1'b0);
    check("rst_ex_en", ex_en, 1'b1);
    check("rst_fa", fa, 1'b0);
    check("rst_busy", ex_busy, 1'b0);
    @(posedge clk); #1; rst = 1'b1;

    // T1: s1<-s2,s3 ; s4<-s1,s5
    step(1'b1, 4'd2, 4'd3, 4'd0, 3'b011, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd1, 4'd5, 4'd0, 3'b011, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    @(negedge clk); check("T1_stall", stall_id, 1'b0);
    idle();
    @(negedge clk); check("T1_fa", fa, 1'b1); check("T1_fb", fb, 1'b0);

    // T2: vector v1 write, scalar s1 read
    step(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); check("T2_stall", stall_id, 1'b0);
    idle();
    @(negedge clk); check("T2_fa", fa, 1'b0);

    // T3: load s3 then consumer via rb
    step(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd0, 4'd3, 4'd0, 3'b010, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    @(negedge clk); check("T3_stall", stall_id, 1'b1); check("T3_bubble", bubble_ex, 1'b1);
    step(1'b1, 4'd0, 4'd3, 4'd0, 3'b010, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    @(negedge clk); check("T3_stall2", stall_id, 1'b0);
    idle();
    @(negedge clk); check("T3_fb", fb, 1'b0);

    // T4: vdiv v7, follower reads v7 via ra
    step(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 1'b1, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= ML; i++) begin
      step(1'b1, 4'd7, 4'd0, 4'd0, 3'b001, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("T4_ex_en", ex_en, (i == ML));
      check("T4_stall", stall_id, (i != ML));
      check("T4_busy", ex_busy, (i >= 2));
    end
    idle();
    @(negedge clk); check("T4_fa_cycle5", fa, 1'b1); check("T4_busy5", ex_busy, 1'b0);

    // T5: load-use and taken branch together
    step(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd2, 4'd0, 4'd0, 3'b001, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("T5_flush", flush_id, 1'b1); check("T5_bubble", bubble_ex, 1'b1);
    check("T5_stall", stall_id, 1'b0);
    idle();

    // T6: async reset in the middle of BUSY
    step(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd5, 4'd0, 4'd0, 3'b001, 1'b1, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
    idle();
    idle();
    @(negedge clk); check("T6_fa_held", fa, 1'b1); check("T6_busy_pre", ex_busy, 1'b1);
    idle();
    #2; rst = 1'b0;
    #1;
    check("T6_busy", ex_busy, 1'b0); check("T6_ex_en", ex_en, 1'b1);
    check("T6_fa", fa, 1'b0); check("T6_stall", stall_id, 1'b0);
    @(posedge clk); #1; rst = 1'b1;
    step(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk); check("T6_issue_stall", stall_id, 1'b0);
    idle();
    @(negedge clk); check("T6_fa_after", fa, 1'b1);
    idle();
    idle();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
